btn_debounce: RTL and testbench

//  Front end for the lock's push-buttons: synchronises raw asynchronous

---
 rtl/lock_pkg.sv | 31 +++
 rtl/btn_debounce_if.sv | 44 ++++
 rtl/btn_debounce_ch.sv | 152 +++++++++++++++
 rtl/btn_debounce.sv | 56 +++++
 tb/tb_btn_debounce.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the lock's push-button front end.
//
// Contents:
//   btn_state_t           per-channel debounce FSM state
//   N_BTN_DEFAULT         default number of buttons on the board
//   DEBOUNCE_CYC_DEFAULT  default stable-cycle count for hardware builds
//   CNT_W_DEFAULT         counter width matching DEBOUNCE_CYC_DEFAULT
//   DEBOUNCE_CYC_SIM      short stable-cycle count used by the bench
//   CNT_W_SIM             counter width matching DEBOUNCE_CYC_SIM
//   is_checking()         true while a channel is qualifying a change
package lock_pkg;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } btn_state_t;

    localparam int N_BTN_DEFAULT        = 2;
    localparam int DEBOUNCE_CYC_DEFAULT = 20000;
    localparam int CNT_W_DEFAULT        = 15;

    localparam int DEBOUNCE_CYC_SIM = 4;
    localparam int CNT_W_SIM        = 3;

    function automatic logic is_checking(input btn_state_t s);
        return (s == CHK_HI) || (s == CHK_LO);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Signal bundle between the raw button pins and the debounced outputs.
//
// Signals:
//   btn_raw      raw asynchronous button pins, 1 = pressed
//   btn_level    debounced level per button
//   btn_press    one-cycle strobe on a 0->1 change of btn_level
//   btn_release  one-cycle strobe on a 1->0 change of btn_level
//   btn_busy     high while any channel is qualifying a change
//
// Modports:
//   master  drives btn_raw, observes the debounced outputs
//   slave   the debouncer: consumes btn_raw, drives the outputs
//
// There is no valid/ready pair here: btn_raw is a free-running level sampled
// every cycle, and every output is valid every cycle after reset.
interface btn_debounce_if
    import lock_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEFAULT
) ();

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             btn_busy;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_busy
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_busy
    );

endinterface

// File: rtl/btn_debounce_ch.sv
// One debounce channel: two-flop synchroniser, stability counter, four-state
// FSM and registered level/press/release outputs.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   btn_raw      raw asynchronous pin for this button
//   btn_level    debounced level (registered)
//   btn_press    one-cycle strobe when btn_level rises (registered)
//   btn_release  one-cycle strobe when btn_level falls (registered)
//   busy         high while the FSM is in CHK_HI or CHK_LO
//   state_dbg    current FSM state, for observation only
//
// A change is accepted only after the synchronised input has disagreed with
// the current level for DEBOUNCE_CYC consecutive cycles. Requires
// DEBOUNCE_CYC >= 2 and 2**CNT_W > DEBOUNCE_CYC.
module btn_debounce_ch
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       busy,
    output btn_state_t state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic s1;
    logic s2;

    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Two-flop synchroniser; nothing downstream ever looks at s1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOW;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            LOW: begin
                if (s2) state_nxt = CHK_HI;
            end
            CHK_HI: begin
                if (!s2)                  state_nxt = LOW;
                else if (cnt == CNT_LAST) state_nxt = HIGH;
            end
            HIGH: begin
                if (!s2) state_nxt = CHK_LO;
            end
            CHK_LO: begin
                if (s2)                   state_nxt = HIGH;
                else if (cnt == CNT_LAST) state_nxt = LOW;
            end
            default: state_nxt = LOW;
        endcase
    end

    // Output / counter logic. The count starts at 1 on entry to a check
    // state, so reaching CNT_LAST with the input still disagreeing marks the
    // DEBOUNCE_CYC-th consecutive sample; the FSM leaves before it can wrap.
    always_comb begin
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            LOW: begin
                if (s2) cnt_nxt = CNT_ONE;
            end
            CHK_HI: begin
                if (!s2) begin
                    cnt_nxt = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = CNT_ZERO;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s2) cnt_nxt = CNT_ONE;
            end
            CHK_LO: begin
                if (s2) begin
                    cnt_nxt = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt     = CNT_ZERO;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                cnt_nxt   = CNT_ZERO;
                level_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs; a reset mid-count drops the count with no strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= CNT_ZERO;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

    assign busy      = is_checking(state);
    assign state_dbg = state;

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: N_BTN independent debounce channels sharing one
// clock, plus a combined busy flag.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   slave side of btn_debounce_if
//           btn_raw      raw button pins (in)
//           btn_level    debounced levels, feeds led_btn.in (out)
//           btn_press    per-button rise strobes (out)
//           btn_release  per-button fall strobes (out)
//           btn_busy     OR of all channels in a check state (out)
//
// The interface instance must be declared with the same N_BTN.
module btn_debounce
    import lock_pkg::*;
#(
    parameter int N_BTN        = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    btn_debounce_if.slave  bus
);

    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] release_v;
    logic [N_BTN-1:0] busy_v;

    // Per-channel FSM states, kept visible for observation.
    btn_state_t ch_state [N_BTN];

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (bus.btn_raw[i]),
            .btn_level   (level_v[i]),
            .btn_press   (press_v[i]),
            .btn_release (release_v[i]),
            .busy        (busy_v[i]),
            .state_dbg   (ch_state[i])
        );
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.btn_busy    = |busy_v;

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;
    import lock_pkg::*;

    localparam int NB = 2;
    localparam int DC = DEBOUNCE_CYC_SIM;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    btn_debounce_if #(.N_BTN(NB)) bus ();

    btn_debounce #(
        .N_BTN        (NB),
        .DEBOUNCE_CYC (DC),
        .CNT_W        (CNT_W_SIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- bookkeeping ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;

    int          n_press;
    int          n_rel;
    logic [NB-1:0] last_press;
    logic [NB-1:0] last_rel;
    logic        busy_seen;

    // ---------------- reference model ----------------
    // A level flips once the pin value seen two clocks late has differed
    // from the current level on DC consecutive clocks.
    logic [NB-1:0] raw_hist[$];
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_press;
    logic [NB-1:0] m_rel;
    logic          m_busy;
    int            run_len [NB];

    task automatic model_edge();
        logic [NB-1:0] seen;
        m_press = '0;
        m_rel   = '0;
        if (rst) begin
            m_level = '0;
            for (int c = 0; c < NB; c++) run_len[c] = 0;
            raw_hist.delete();
            raw_hist.push_back('0);
            raw_hist.push_back('0);
        end else begin
            seen = raw_hist[0];
            for (int c = 0; c < NB; c++) begin
                if (seen[c] != m_level[c]) begin
                    run_len[c]++;
                    if (run_len[c] == DC) begin
                        m_level[c] = seen[c];
                        if (seen[c]) m_press[c] = 1'b1;
                        else         m_rel[c]   = 1'b1;
                        run_len[c] = 0;
                    end
                end else begin
                    run_len[c] = 0;
                end
            end
            raw_hist.push_back(bus.btn_raw);
            void'(raw_hist.pop_front());
        end
        m_busy = 1'b0;
        for (int c = 0; c < NB; c++) if (run_len[c] != 0) m_busy = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("level",   32'(bus.btn_level),   32'(m_level));
        check("press",   32'(bus.btn_press),   32'(m_press));
        check("release", 32'(bus.btn_release), 32'(m_rel));
        check("busy",    32'(bus.btn_busy),    32'(m_busy));
        if (bus.btn_press != '0) begin
            n_press++;
            last_press = bus.btn_press;
        end
        if (bus.btn_release != '0) begin
            n_rel++;
            last_rel = bus.btn_release;
        end
        if (bus.btn_busy === 1'b1) busy_seen = 1'b1;
    endtask

    task automatic clear_stats();
        n_press    = 0;
        n_rel      = 0;
        last_press = '0;
        last_rel   = '0;
        busy_seen  = 1'b0;
    endtask

    // Steps until btn_level equals tgt; n is the number of clocks taken.
    task automatic wait_level(input logic [NB-1:0] tgt, input int max_cyc, output int n);
        n = 0;
        while (bus.btn_level !== tgt && n < max_cyc) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int hold;

        raw_hist.push_back('0);
        raw_hist.push_back('0);
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        m_busy  = 1'b0;
        for (int c = 0; c < NB; c++) run_len[c] = 0;
        clear_stats();

        // Reset with both pins pressed.
        rst         = 1'b1;
        bus.btn_raw = 2'b11;
        repeat (3) step();
        rst = 1'b0;
        wait_level(2'b11, 20, n);
        check("reset_release_latency", 32'(n), 32'(2 + DC));

        bus.btn_raw = 2'b00;
        wait_level(2'b00, 20, n);
        repeat (2) step();

        // Clean press on bit 0.
        clear_stats();
        bus.btn_raw = 2'b01;
        wait_level(2'b01, 20, n);
        check("press_latency", 32'(n), 32'(2 + DC));
        repeat (4) step();
        check("press_count", 32'(n_press), 32'd1);
        check("press_value", 32'(last_press), 32'h1);
        check("press_no_release", 32'(n_rel), 32'd0);

        bus.btn_raw = 2'b00;
        wait_level(2'b00, 20, n);
        repeat (2) step();

        // Glitch shorter than the debounce window.
        clear_stats();
        bus.btn_raw = 2'b01;
        repeat (3) step();
        bus.btn_raw = 2'b00;
        repeat (8) step();
        check("glitch_level", 32'(bus.btn_level), 32'h0);
        check("glitch_press", 32'(n_press), 32'd0);
        check("glitch_release", 32'(n_rel), 32'd0);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_idle", 32'(bus.btn_busy), 32'd0);

        // Bounce on bit 1, then hold pressed.
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            bus.btn_raw = bus.btn_raw ^ 2'b10;
            repeat (2) step();
        end
        bus.btn_raw = bus.btn_raw ^ 2'b10;
        wait_level(2'b10, 20, n);
        check("bounce_latency", 32'(n), 32'(2 + DC));
        repeat (3) step();
        check("bounce_press_count", 32'(n_press), 32'd1);
        check("bounce_press_value", 32'(last_press), 32'h2);

        bus.btn_raw = 2'b00;
        wait_level(2'b00, 20, n);
        repeat (2) step();

        // Simultaneous press and release.
        clear_stats();
        bus.btn_raw = 2'b11;
        wait_level(2'b11, 20, n);
        check("simul_press_latency", 32'(n), 32'(2 + DC));
        check("simul_press_count", 32'(n_press), 32'd1);
        check("simul_press_value", 32'(last_press), 32'h3);
        repeat (3) step();
        clear_stats();
        bus.btn_raw = 2'b00;
        wait_level(2'b00, 20, n);
        check("simul_release_latency", 32'(n), 32'(2 + DC));
        check("simul_release_count", 32'(n_rel), 32'd1);
        check("simul_release_value", 32'(last_rel), 32'h3);
        repeat (3) step();

        // Reset in the 4th cycle of a check.
        clear_stats();
        bus.btn_raw = 2'b10;
        repeat (5) step();
        rst = 1'b1;
        repeat (2) step();
        check("midrst_level", 32'(bus.btn_level), 32'h0);
        check("midrst_no_press", 32'(n_press), 32'd0);
        rst = 1'b0;
        wait_level(2'b10, 20, n);
        check("midrst_reaccept_latency", 32'(n), 32'(2 + DC));
        check("midrst_press_count", 32'(n_press), 32'd1);

        // Random pin activity with occasional resets.
        for (int k = 0; k < 60; k++) begin
            bus.btn_raw = NB'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) rst = 1'b1;
            hold = $urandom_range(1, 9);
            step();
            rst = 1'b0;
            repeat (hold - 1) step();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
